// File: rtl/fft_mem_pkg.sv
// Shared constants and helpers for the FFT working-data buffer RAM.
package fft_mem_pkg;

  // Deepest output pipeline supported behind the array read register.
  localparam int RD_PIPE_MAX = 2;

  // Bank encoding for the ping-pong bank bit.
  localparam logic BANK_A = 1'b0;
  localparam logic BANK_B = 1'b1;

  // Physical word address width: one extra bit selects the bank in ping-pong mode.
  function automatic int phys_awidth(input int awidth, input int pingpong);
    return awidth + ((pingpong != 0) ? 1 : 0);
  endfunction

endpackage

// File: rtl/fft_mem_outstage.sv
// One output pipeline stage: data plus valid, freezes when disabled,
// synchronous clear has priority over enable.
module fft_mem_outstage #(
  parameter int DWIDTH = 64
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              en_i,
  input  logic              clr_i,
  input  logic [DWIDTH-1:0] d_i,
  input  logic              v_i,
  output logic [DWIDTH-1:0] d_o,
  output logic              v_o
);

  logic [DWIDTH-1:0] d_q;
  logic              v_q;

  // Stage register: clear wins, otherwise advance only when enabled.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      d_q <= '0;
      v_q <= 1'b0;
    end else if (clr_i) begin
      d_q <= '0;
      v_q <= 1'b0;
    end else if (en_i) begin
      d_q <= d_i;
      v_q <= v_i;
    end
  end

  assign d_o = d_q;
  assign v_o = v_q;

endmodule

// File: rtl/fft_pingpong_lsram.sv
// Single-clock two-port FFT buffer RAM with optional ping-pong banks,
// selectable read-during-write forwarding and a configurable output pipeline.
//
// Bank state (PINGPONG=1):
//   state  | meaning
//   BANK_A | read bank 0, write bank 1
//   BANK_B | read bank 1, write bank 0
module fft_pingpong_lsram
  import fft_mem_pkg::*;
#(
  parameter int DWIDTH   = 64,
  parameter int AWIDTH   = 11,
  parameter int PINGPONG = 1,
  parameter int RD_PIPE  = 0,
  parameter int BYPASS   = 1
) (
  input  logic              CLOCK,
  input  logic              RST,
  input  logic [DWIDTH-1:0] DI,
  input  logic [AWIDTH-1:0] WADDR,
  input  logic              WE,
  input  logic [AWIDTH-1:0] RADDR,
  input  logic              RE,
  input  logic              SWAP,
  input  logic              DO_EN,
  input  logic              DO_RST,
  output logic [DWIDTH-1:0] DO,
  output logic              DO_VALID,
  output logic              RBANK
);

  localparam int PAW    = phys_awidth(AWIDTH, PINGPONG);
  localparam int DEPTH  = 1 << PAW;
  localparam int NSTAGE = (RD_PIPE > RD_PIPE_MAX) ? RD_PIPE_MAX : RD_PIPE;

  logic [DWIDTH-1:0] mem_q [DEPTH];

  logic              rbank_q;
  logic              rbank_d;
  logic [PAW-1:0]    wa_phys;
  logic [PAW-1:0]    ra_phys;
  logic              collide;
  logic [DWIDTH-1:0] rd_word;

  // Synchronous read latch inside the RAM, then the array read register.
  logic [DWIDTH-1:0] raw_d_q;
  logic              raw_v_q;
  logic [DWIDTH-1:0] arr_d_q;
  logic              arr_v_q;

  logic [DWIDTH-1:0] pipe_d [NSTAGE+1];
  logic [NSTAGE:0]   pipe_v;

  // The write bank is always the one opposite the read bank.
  if (PINGPONG != 0) begin : g_pp_addr
    assign wa_phys = {~rbank_q, WADDR};
    assign ra_phys = { rbank_q, RADDR};
  end else begin : g_sp_addr
    assign wa_phys = WADDR;
    assign ra_phys = RADDR;
  end

  // Bank state register.
  always_ff @(posedge CLOCK or posedge RST) begin
    if (RST) begin
      rbank_q <= BANK_A;
    end else begin
      rbank_q <= rbank_d;
    end
  end

  // Bank next-state: each sampled SWAP toggles; ignored in single-bank mode.
  always_comb begin
    rbank_d = rbank_q;
    if ((PINGPONG != 0) && SWAP) begin
      rbank_d = (rbank_q == BANK_A) ? BANK_B : BANK_A;
    end
  end

  // Bank output: stays at BANK_A forever when ping-pong is disabled.
  always_comb begin
    RBANK = rbank_q;
  end

  // Array write port; no reset so the array maps onto LSRAM.
  always_ff @(posedge CLOCK) begin
    if (WE) begin
      mem_q[wa_phys] <= DI;
    end
  end

  // A same-edge collision can only occur in single-bank mode.
  assign collide = WE && (wa_phys == ra_phys);
  assign rd_word = ((BYPASS != 0) && collide) ? DI : mem_q[ra_phys];

  // Read latch: captures at the accept edge so old/new data choice is fixed there.
  always_ff @(posedge CLOCK or posedge RST) begin
    if (RST) begin
      raw_d_q <= '0;
      raw_v_q <= 1'b0;
    end else if (DO_RST) begin
      raw_d_q <= '0;
      raw_v_q <= 1'b0;
    end else if (DO_EN) begin
      raw_v_q <= RE;
      if (RE) begin
        raw_d_q <= rd_word;
      end
    end
  end

  // Array read register, frozen together with the rest of the pipeline.
  always_ff @(posedge CLOCK or posedge RST) begin
    if (RST) begin
      arr_d_q <= '0;
      arr_v_q <= 1'b0;
    end else if (DO_RST) begin
      arr_d_q <= '0;
      arr_v_q <= 1'b0;
    end else if (DO_EN) begin
      arr_d_q <= raw_d_q;
      arr_v_q <= raw_v_q;
    end
  end

  assign pipe_d[0] = arr_d_q;
  assign pipe_v[0] = arr_v_q;

  for (genvar g = 0; g < NSTAGE; g++) begin : g_stage
    fft_mem_outstage #(
      .DWIDTH (DWIDTH)
    ) u_stage (
      .clk_i (CLOCK),
      .rst_i (RST),
      .en_i  (DO_EN),
      .clr_i (DO_RST),
      .d_i   (pipe_d[g]),
      .v_i   (pipe_v[g]),
      .d_o   (pipe_d[g+1]),
      .v_o   (pipe_v[g+1])
    );
  end

  assign DO       = pipe_d[NSTAGE];
  assign DO_VALID = pipe_v[NSTAGE];

endmodule

// File: tb/tb_fft_pingpong_lsram.sv
// Directed bench: a ping-pong instance with a deep output pipeline, plus two
// single-bank instances differing only in read-during-write behaviour.
module tb_fft_pingpong_lsram;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [63:0] di;
  logic [10:0] waddr, raddr;
  logic        we, re, swap, do_en, do_rst;
  logic [63:0] pp_do;
  logic        pp_vld, pp_rbank;

  logic [7:0]  s_di;
  logic [3:0]  s_waddr, s_raddr;
  logic        s_we, s_re, s_swap, s_do_en, s_do_rst;
  logic [7:0]  byp_do, nob_do;
  logic        byp_vld, nob_vld, byp_rbank, nob_rbank;

  int n_tests = 0;
  int n_fail  = 0;

  fft_pingpong_lsram #(
    .DWIDTH(64), .AWIDTH(11), .PINGPONG(1), .RD_PIPE(2), .BYPASS(1)
  ) u_pp (
    .CLOCK(clk), .RST(rst), .DI(di), .WADDR(waddr), .WE(we), .RADDR(raddr), .RE(re),
    .SWAP(swap), .DO_EN(do_en), .DO_RST(do_rst), .DO(pp_do), .DO_VALID(pp_vld), .RBANK(pp_rbank)
  );

  fft_pingpong_lsram #(
    .DWIDTH(8), .AWIDTH(4), .PINGPONG(0), .RD_PIPE(0), .BYPASS(1)
  ) u_byp (
    .CLOCK(clk), .RST(rst), .DI(s_di), .WADDR(s_waddr), .WE(s_we), .RADDR(s_raddr), .RE(s_re),
    .SWAP(s_swap), .DO_EN(s_do_en), .DO_RST(s_do_rst), .DO(byp_do), .DO_VALID(byp_vld), .RBANK(byp_rbank)
  );

  fft_pingpong_lsram #(
    .DWIDTH(8), .AWIDTH(4), .PINGPONG(0), .RD_PIPE(0), .BYPASS(0)
  ) u_nob (
    .CLOCK(clk), .RST(rst), .DI(s_di), .WADDR(s_waddr), .WE(s_we), .RADDR(s_raddr), .RE(s_re),
    .SWAP(s_swap), .DO_EN(s_do_en), .DO_RST(s_do_rst), .DO(nob_do), .DO_VALID(nob_vld), .RBANK(nob_rbank)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Single read on the ping-pong instance; result is due three edges after acceptance.
  task automatic pp_read(input logic [10:0] a, input logic [63:0] exp, input string tag);
    raddr = a;
    re    = 1'b1;
    tick();
    re = 1'b0;
    repeat (3) tick();
    check({tag, "_vld"}, {63'd0, pp_vld}, 64'd1);
    check({tag, "_do"}, pp_do, exp);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [63:0] v;
    rst = 1'b1; di = '0; waddr = '0; raddr = '0; we = 1'b0; re = 1'b0;
    swap = 1'b0; do_en = 1'b1; do_rst = 1'b0;
    s_di = '0; s_waddr = '0; s_raddr = '0; s_we = 1'b0; s_re = 1'b0;
    s_swap = 1'b0; s_do_en = 1'b1; s_do_rst = 1'b0;

    repeat (2) tick();
    check("rst_do", pp_do, 64'd0);
    check("rst_vld", {63'd0, pp_vld}, 64'd0);
    check("rst_rbank", {63'd0, pp_rbank}, 64'd0);
    rst = 1'b0;
    tick();

    // Latency through RD_PIPE=2 at the top-of-bank address.
    di = 64'hDEAD_BEEF_0123_4567; waddr = 11'h7FF; we = 1'b1;
    tick();
    we = 1'b0;
    swap = 1'b1;
    tick();
    swap = 1'b0;
    check("swap_rbank", {63'd0, pp_rbank}, 64'd1);
    raddr = 11'h7FF; re = 1'b1;
    tick();
    re = 1'b0;
    check("lat_e0_vld", {63'd0, pp_vld}, 64'd0);
    tick();
    check("lat_e1_vld", {63'd0, pp_vld}, 64'd0);
    tick();
    check("lat_e2_vld", {63'd0, pp_vld}, 64'd0);
    tick();
    check("lat_e3_vld", {63'd0, pp_vld}, 64'd1);
    check("lat_e3_do", pp_do, 64'hDEAD_BEEF_0123_4567);

    // Ping-pong isolation: RBANK=1 so bank 0 is the write bank.
    for (int i = 0; i < 8; i++) begin
      waddr = 11'(i); di = 64'(i); we = 1'b1;
      tick();
    end
    we = 1'b0;
    swap = 1'b1;
    tick();
    swap = 1'b0;
    check("iso_rbank0", {63'd0, pp_rbank}, 64'd0);
    for (int c = 0; c < 11; c++) begin
      if (c < 8) begin
        v = 64'(c);
        we = 1'b1; waddr = 11'(c); di = ~v;
        re = 1'b1; raddr = 11'(c);
      end else begin
        we = 1'b0; re = 1'b0;
      end
      tick();
      if (c >= 3) begin
        check("iso_a_vld", {63'd0, pp_vld}, 64'd1);
        check("iso_a_do", pp_do, 64'(c - 3));
      end
    end
    we = 1'b0; re = 1'b0;
    swap = 1'b1;
    tick();
    swap = 1'b0;
    check("iso_rbank1", {63'd0, pp_rbank}, 64'd1);
    for (int c = 0; c < 11; c++) begin
      if (c < 8) begin
        re = 1'b1; raddr = 11'(c);
      end else begin
        re = 1'b0;
      end
      tick();
      if (c >= 3) begin
        v = 64'(c - 3);
        check("iso_b_vld", {63'd0, pp_vld}, 64'd1);
        check("iso_b_do", pp_do, ~v);
      end
    end
    re = 1'b0;
    pp_read(11'h7FF, 64'hDEAD_BEEF_0123_4567, "iso_top");

    // SWAP, WE and RE on one edge use the pre-swap banks (read 1, write 0).
    swap = 1'b1; we = 1'b1; waddr = 11'd3; di = 64'hAAAA_5555_0000_FFFF;
    re = 1'b1; raddr = 11'd2;
    tick();
    swap = 1'b0; we = 1'b0; re = 1'b0;
    check("swapacc_rbank", {63'd0, pp_rbank}, 64'd0);
    repeat (3) tick();
    v = 64'd2;
    check("swapacc_rd_vld", {63'd0, pp_vld}, 64'd1);
    check("swapacc_rd_do", pp_do, ~v);
    pp_read(11'd3, 64'hAAAA_5555_0000_FFFF, "swapacc_wr");
    pp_read(11'd2, 64'd2, "swapacc_keep");

    // Stall: three reads, then four disabled edges with a dropped RE inside.
    for (int k = 0; k < 3; k++) begin
      raddr = 11'(4 + k); re = 1'b1;
      tick();
    end
    re = 1'b0;
    tick();
    check("stall_first_do", pp_do, 64'd4);
    do_en = 1'b0;
    for (int k = 0; k < 4; k++) begin
      re = (k == 1);
      raddr = 11'd7;
      tick();
      check("stall_hold_do", pp_do, 64'd4);
      check("stall_hold_vld", {63'd0, pp_vld}, 64'd1);
    end
    re = 1'b0; do_en = 1'b1;
    tick();
    check("stall_r1_do", pp_do, 64'd5);
    tick();
    check("stall_r2_do", pp_do, 64'd6);
    check("stall_r2_vld", {63'd0, pp_vld}, 64'd1);
    tick();
    check("stall_drop_vld", {63'd0, pp_vld}, 64'd0);

    // Clear during a stall discards everything in flight.
    for (int k = 0; k < 3; k++) begin
      raddr = 11'(4 + k); re = 1'b1;
      tick();
    end
    re = 1'b0;
    tick();
    check("clr_first_do", pp_do, 64'd4);
    do_en = 1'b0;
    tick();
    do_rst = 1'b1;
    tick();
    do_rst = 1'b0;
    check("clr_do", pp_do, 64'd0);
    check("clr_vld", {63'd0, pp_vld}, 64'd0);
    do_en = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("clr_after_vld", {63'd0, pp_vld}, 64'd0);
    end
    pp_read(11'd7, 64'd7, "clr_next");

    // Asynchronous reset mid-traffic, checked between clock edges.
    swap = 1'b1;
    tick();
    swap = 1'b0;
    v = 64'd5;
    pp_read(11'd5, ~v, "prerst");
    raddr = 11'd6; re = 1'b1;
    tick();
    re = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check("arst_do", pp_do, 64'd0);
    check("arst_vld", {63'd0, pp_vld}, 64'd0);
    check("arst_rbank", {63'd0, pp_rbank}, 64'd0);
    tick();
    rst = 1'b0;
    repeat (3) tick();
    check("arst_flush_vld", {63'd0, pp_vld}, 64'd0);
    pp_read(11'd7, 64'd7, "arst_next");

    // Single-bank collision behaviour.
    s_waddr = 4'd5; s_di = 8'h11; s_we = 1'b1;
    tick();
    s_we = 1'b1; s_waddr = 4'd5; s_di = 8'h22; s_re = 1'b1; s_raddr = 4'd5;
    tick();
    s_we = 1'b0; s_re = 1'b0;
    tick();
    check("col_byp_do", {56'd0, byp_do}, 64'h22);
    check("col_byp_vld", {63'd0, byp_vld}, 64'd1);
    check("col_nob_do", {56'd0, nob_do}, 64'h11);
    check("col_nob_vld", {63'd0, nob_vld}, 64'd1);
    s_re = 1'b1; s_raddr = 4'd5;
    tick();
    s_re = 1'b0;
    tick();
    check("col_next_byp", {56'd0, byp_do}, 64'h22);
    check("col_next_nob", {56'd0, nob_do}, 64'h22);
    s_we = 1'b1; s_waddr = 4'd9; s_di = 8'h33;
    tick();
    s_we = 1'b0; s_re = 1'b1; s_raddr = 4'd9;
    tick();
    s_re = 1'b0;
    tick();
    check("wthenr_byp", {56'd0, byp_do}, 64'h33);
    check("wthenr_nob", {56'd0, nob_do}, 64'h33);
    s_swap = 1'b1;
    tick();
    s_swap = 1'b0;
    check("sp_rbank", {63'd0, byp_rbank}, 64'd0);
    s_re = 1'b1; s_raddr = 4'd5;
    tick();
    s_re = 1'b0;
    tick();
    check("sp_swap_ignored", {56'd0, nob_do}, 64'h22);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
